// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file for the MIPS datapath.
// Two combinational read ports, one synchronous byte-enabled write port,
// optional hardwired zero entry and optional same-cycle write-to-read bypass.
// Storage is plain flops so that reset can clear every entry.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 WrEn,
  input  logic [ADDR_W-1:0]    WrAddr,
  input  logic [WIDTH-1:0]     WrData,
  input  logic [WIDTH/8-1:0]   WrByteEn,
  input  logic [ADDR_W-1:0]    RdAddrA,
  output logic [WIDTH-1:0]     RdDataA,
  input  logic [ADDR_W-1:0]    RdAddrB,
  output logic [WIDTH-1:0]     RdDataB
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_is_zero;
  logic             wr_active;

  // Writes to the hardwired zero entry are dropped; reset discards any write.
  assign wr_is_zero = (ZERO_REG != 0) && (WrAddr == '0);
  assign wr_active  = WrEn && !Reset && !wr_is_zero;

  // Read mux for one port: stored entry, per-byte bypass merge, zero entry and
  // reset forcing applied in increasing priority.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              rst,
    input logic              wr_act,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [WIDTH-1:0]  wr_data,
    input logic [NBYTES-1:0] wr_be
  );
    logic [WIDTH-1:0] data;
    data = stored;
    if ((BYPASS != 0) && wr_act && (addr == wr_addr)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) data[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    if (rst) data = '0;
    return data;
  endfunction

  // Storage update: reset clears all entries, otherwise byte-masked write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_active) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (WrByteEn[b]) mem[WrAddr][8*b +: 8] <= WrData[8*b +: 8];
      end
    end
  end

  // Read port A.
  always_comb begin
    RdDataA = read_port(RdAddrA, mem[RdAddrA], Reset, wr_active,
                        WrAddr, WrData, WrByteEn);
  end

  // Read port B.
  always_comb begin
    RdDataB = read_port(RdAddrB, mem[RdAddrB], Reset, wr_active,
                        WrAddr, WrData, WrByteEn);
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file. Three instances share the stimulus:
// dut 0 = defaults (zero entry + bypass), dut 1 = no zero entry,
// dut 2 = no bypass. Stimulus pushes expectations; a negedge monitor checks.
module tb_register_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic [3:0]  WrByteEn;
  logic [4:0]  RdAddrA;
  logic [4:0]  RdAddrB;
  logic [31:0] rda [3];
  logic [31:0] rdb [3];

  typedef struct {
    string       name;
    int          sel;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   done    = 1'b0;

  always #5 Clk = ~Clk;

  register_file u_dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdDataA(rda[0]),
    .RdAddrB(RdAddrB), .RdDataB(rdb[0])
  );

  register_file #(.ZERO_REG(0)) u_nz (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdDataA(rda[1]),
    .RdAddrB(RdAddrB), .RdDataB(rdb[1])
  );

  register_file #(.BYPASS(0)) u_nb (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdDataA(rda[2]),
    .RdAddrB(RdAddrB), .RdDataB(rdb[2])
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_val(input string n, input int sel, input int port,
                            input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.port = port; e.exp = v;
    q.push_back(e);
  endtask

  task automatic expect_all(input string n, input int port, input logic [31:0] v);
    for (int s = 0; s < 3; s++) expect_val(n, s, port, v);
  endtask

  task automatic drive_wr(input logic en, input logic [4:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    WrEn = en; WrAddr = a; WrData = d; WrByteEn = be;
  endtask

  // Monitor: outputs are settled mid-cycle, so compare everything queued.
  always @(negedge Clk) begin
    logic [31:0] act;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      act = (e.port == 0) ? rda[e.sel] : rdb[e.sel];
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s dut%0d port%s: got %h expected %h",
                    e.name, e.sel, (e.port == 0) ? "A" : "B", act, e.exp);
    end
  end

  initial begin
    Reset = 1'b1;
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    RdAddrA = 5'd0; RdAddrB = 5'd0;
    tick(); tick();

    // fill every entry with all ones
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive_wr(1'b1, 5'(i), 32'hFFFF_FFFF, 4'hF);
      tick();
    end
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    RdAddrA = 5'd0; RdAddrB = 5'd10;
    expect_val("fill_r0", 0, 0, 32'h0);
    expect_val("fill_r0", 1, 0, 32'hFFFF_FFFF);
    expect_val("fill_r0", 2, 0, 32'h0);
    expect_all("fill_r10", 1, 32'hFFFF_FFFF);
    tick();

    // reset together with a write: outputs forced low, no bypass, write lost
    Reset = 1'b1;
    drive_wr(1'b1, 5'd3, 32'h8765_4321, 4'hF);
    RdAddrA = 5'd3; RdAddrB = 5'd10;
    expect_all("rst_fwd_a", 0, 32'h0);
    expect_all("rst_fwd_b", 1, 32'h0);
    tick();
    Reset = 1'b0;
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    for (int i = 0; i < 32; i++) begin
      RdAddrA = 5'(i); RdAddrB = 5'(31 - i);
      expect_val("rst_clear_a", 0, 0, 32'h0);
      expect_val("rst_clear_b", 0, 1, 32'h0);
      expect_val("rst_clear_nz", 1, 0, 32'h0);
      tick();
    end

    // basic write/read
    drive_wr(1'b1, 5'd5, 32'h6748_0FAC, 4'hF); tick();
    drive_wr(1'b1, 5'd31, 32'h1110_1110, 4'hF); tick();
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    RdAddrA = 5'd5; RdAddrB = 5'd31;
    expect_all("basic_r5", 0, 32'h6748_0FAC);
    expect_all("basic_r31", 1, 32'h1110_1110);
    tick();
    RdAddrB = 5'd5;
    expect_all("same_addr_a", 0, 32'h6748_0FAC);
    expect_all("same_addr_b", 1, 32'h6748_0FAC);
    tick();

    // byte enables, checked through the bypass during the write
    drive_wr(1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF); tick();
    drive_wr(1'b1, 5'd7, 32'hCAFE_BABE, 4'b0101);
    RdAddrA = 5'd7; RdAddrB = 5'd5;
    expect_val("be_fwd", 0, 0, 32'hDEFE_BEBE);
    expect_val("be_fwd", 1, 0, 32'hDEFE_BEBE);
    expect_val("be_nofwd", 2, 0, 32'hDEAD_BEEF);
    tick();
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    expect_all("be_stored", 0, 32'hDEFE_BEBE);
    tick();

    // zero entry
    drive_wr(1'b1, 5'd0, 32'h1234_5678, 4'hF);
    RdAddrA = 5'd0; RdAddrB = 5'd0;
    expect_val("zero_fwd", 0, 0, 32'h0);
    expect_val("zero_fwd", 1, 0, 32'h1234_5678);
    expect_val("zero_fwd", 2, 0, 32'h0);
    tick();
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    expect_val("zero_rd", 0, 1, 32'h0);
    expect_val("zero_rd", 1, 1, 32'h1234_5678);
    expect_val("zero_rd", 2, 1, 32'h0);
    tick();

    // partial bypass on an entry cleared by reset
    drive_wr(1'b1, 5'd9, 32'hAABB_CCDD, 4'b1100);
    RdAddrA = 5'd9; RdAddrB = 5'd7;
    expect_val("byp_pre", 0, 0, 32'hAABB_0000);
    expect_val("byp_pre", 1, 0, 32'hAABB_0000);
    expect_val("byp_pre", 2, 0, 32'h0);
    expect_all("byp_other_port", 1, 32'hDEFE_BEBE);
    tick();
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    expect_all("byp_post", 0, 32'hAABB_0000);
    tick();

    // write enable with no bytes selected is a no-op
    drive_wr(1'b1, 5'd5, 32'hFFFF_FFFF, 4'h0);
    RdAddrA = 5'd5;
    expect_all("be0_fwd", 0, 32'h6748_0FAC);
    tick();
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    expect_all("be0_stored", 0, 32'h6748_0FAC);
    tick();

    // partial writes accumulate across back-to-back cycles
    drive_wr(1'b1, 5'd12, 32'h0000_00AA, 4'b0001); tick();
    drive_wr(1'b1, 5'd12, 32'h0000_BB00, 4'b0010);
    RdAddrA = 5'd12; RdAddrB = 5'd12;
    expect_val("acc_fwd", 0, 1, 32'h0000_BBAA);
    expect_val("acc_fwd", 2, 1, 32'h0000_00AA);
    tick();
    drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
    expect_all("acc_stored", 0, 32'h0000_BBAA);
    tick();

    tick(); tick();
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog: the stimulus is bounded, but never let the run hang.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file for the MIPS CPU datapath; the generalised successor of the single 32-bit `register` block. It holds `DEPTH` entries of `WIDTH` bits and provides two asynchronous read ports and one synchronous write port with byte enables. An optional hardwired zero entry and an optional write-to-read bypass are included. It sits between instruction decode (read) and write-back (write).

## Interface
- `WIDTH`, 32, entry width in bits; must be a multiple of 8
- `DEPTH`, 32, number of entries; power of two, ≥ 2
- `ADDR_W`, $clog2(DEPTH), address width
- `ZERO_REG`, 1, 1 = entry 0 always reads 0 and ignores writes (MIPS `$zero`)
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching read ports
- `Clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high; clears every entry
- `WrEn`  in  1  write enable
- `WrAddr`  in  ADDR_W  write address
- `WrData`  in  WIDTH  write data
- `WrByteEn`  in  WIDTH/8  per-byte write enable; bit i covers `WrData[8i+7:8i]`
- `RdAddrA`  in  ADDR_W  read port A address
- `RdDataA`  out  WIDTH  read port A data
- `RdAddrB`  in  ADDR_W  read port B address
- `RdDataB`  out  WIDTH  read port B data

## Operation
- Storage: `DEPTH` × `WIDTH` flops. No memory macro is used because reset must clear every entry.
- Reset: a rising `Clk` with `Reset`=1 sets every entry to 0. Any write presented in that cycle is discarded.
- Write: a rising `Clk` with `Reset`=0 and `WrEn`=1 updates entry `WrAddr`.
  - Only bytes whose `WrByteEn` bit is 1 change; the other bytes keep their value.
  - `WrByteEn`=0 with `WrEn`=1 is a legal no-op.
- Zero entry: with `ZERO_REG`=1, writes to address 0 are dropped and reads of address 0 return 0 unconditionally. With `ZERO_REG`=0, entry 0 is ordinary.
- Read: combinational from the addressed entry. Both ports are independent and may use the same address.
- Bypass (`BYPASS`=1): a read port's byte i comes from `WrData` byte i when all of these hold:
  - `WrEn`=1 and `Reset`=0;
  - the port's address equals `WrAddr`;
  - `WrByteEn[i]`=1;
  - the address is not the zero entry under `ZERO_REG`=1.
  
  All other bytes come from storage. The result is a per-byte merge.
- `BYPASS`=0: reads return stored contents only; the written value appears after the edge.
- While `Reset`=1, `RdDataA` and `RdDataB` are forced to 0, independent of address and storage contents.
- Out-of-range addresses cannot occur because `DEPTH` = 2^`ADDR_W`.

## Timing
- Reset value of every output: `RdDataA`=0 and `RdDataB`=0 while `Reset`=1 and at every address after reset.
- Write latency: 1 cycle. Data written at edge N is visible from storage after edge N.
- Bypass latency: 0 cycles, combinational from `WrData`, `WrEn`, `WrByteEn` and `WrAddr` to `RdData*`.
- Reset mid-operation: `Reset` asserted in the same cycle as a write means reset wins. The entry is 0 after the edge and the bypass is suppressed in that cycle.
- Back-to-back writes to one address: the last edge wins. Partial byte writes accumulate across cycles.
- No handshake; every input is sampled every cycle.
- Combinational path: read address → `RdData` is a `DEPTH`:1 mux per port, plus the bypass compare and a 2:1 mux per byte.

## Test plan
- Reset clears all: load all 32 entries with 0xFFFFFFFF, assert `Reset` for 1 cycle, then read each address on both ports → all 0. `RdData*`=0 while `Reset`=1.
- Basic write/read: write 0x67480FAC to r5 and 0x11101110 to r31 with `WrByteEn`=4'hF. Read A=5, B=31 → 0x67480FAC and 0x11101110. Same address on both ports → identical data.
- Byte enables: r7=0xDEADBEEF, then write 0xCAFEBABE with `WrByteEn`=4'b0101 → r7 reads 0xDEFEBEBE.
- Zero register: write 0x12345678 to r0, then read → 0. Repeat with `ZERO_REG`=0 → reads 0x12345678.
- Bypass: r9=0x00000000. In one cycle, write 0xAABBCCDD to r9 with `WrByteEn`=4'b1100 while A reads r9 → A=0xAABB0000 before the edge. With `BYPASS`=0 → A=0 before the edge and 0xAABB0000 after.
- Reset vs write: `Reset`=1 with `WrEn`=1 writing 0x87654321 to r3 → r3 reads 0 after the edge, and no bypass value appears during that cycle.
